// File: rtl/vec_pkg.sv
// Shared constants, state encoding and payload types for the vector writeback stage.
package vec_pkg;

    localparam int unsigned LANES   = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned VREG_AW = 3;
    localparam int unsigned FLAGS_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } wb_state_e;

    typedef logic [LANES-1:0][DATA_W-1:0] lane_data_t;

    // Captured vector: destination register plus all lane results
    typedef struct packed {
        logic [VREG_AW-1:0] vdst;
        lane_data_t         res;
    } vec_t;

    // One register-file write beat
    typedef struct packed {
        logic [VREG_AW-1:0] vreg;
        logic [VREG_AW-1:0] lane;
        logic [DATA_W-1:0]  data;
    } wr_t;

endpackage

// File: rtl/vec_writeback_if.sv
// Result-capture, register-file write and hazard-query signals of the writeback stage.
interface vec_writeback_if;
    import vec_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [VREG_AW-1:0]   in_vdst;
    logic [LANES-1:0]     in_mask;
    logic [DATA_W-1:0]    res_a;
    logic [DATA_W-1:0]    res_b;
    logic [DATA_W-1:0]    res_c;
    logic [DATA_W-1:0]    res_d;
    logic [DATA_W-1:0]    res_e;

    logic                 wr_en;
    logic [VREG_AW-1:0]   wr_vreg;
    logic [VREG_AW-1:0]   wr_lane;
    logic [DATA_W-1:0]    wr_data;
    logic                 done;

    logic                 chk_en;
    logic [VREG_AW-1:0]   chk_vreg;
    logic                 stall;
    logic [FLAGS_W-1:0]   vflags;

    modport master (
        output in_valid, in_vdst, in_mask, res_a, res_b, res_c, res_d, res_e,
        output chk_en, chk_vreg,
        input  in_ready, wr_en, wr_vreg, wr_lane, wr_data, done, stall, vflags
    );

    modport slave (
        input  in_valid, in_vdst, in_mask, res_a, res_b, res_c, res_d, res_e,
        input  chk_en, chk_vreg,
        output in_ready, wr_en, wr_vreg, wr_lane, wr_data, done, stall, vflags
    );

endinterface

// File: rtl/vwb_lane_pick.sv
// Priority encoder: lowest set lane of a mask, as an index and as a one-hot clear vector.
module vwb_lane_pick
    import vec_pkg::*;
(
    input  logic [LANES-1:0]   mask,
    output logic [VREG_AW-1:0] idx,
    output logic [LANES-1:0]   clr
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        idx = '0;
        clr = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx    = VREG_AW'(i);
                clr    = '0;
                clr[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_writeback.sv
// Captures a 5-lane result vector and drains it one masked lane per cycle into the VRF write port.
// Optional flag generation is built when VWB_FLAGS_EN is defined.
module vec_writeback
    import vec_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    vec_writeback_if.slave bus
);

    wb_state_e          state, state_nxt;
    logic [LANES-1:0]   pend, pend_nxt;
    logic [LANES-1:0]   clr_q, clr_nxt;
    vec_t               vec_q, vec_nxt;
    wr_t                wr_q, wr_nxt;
    logic               wr_en_q, wr_en_nxt;
    logic               done_q, done_nxt;
    logic               ready_q;
    logic [VREG_AW-1:0] pick_idx;

    // Lane selection runs on next-cycle pending mask so write outputs can be registered
    vwb_lane_pick u_pick (
        .mask (pend_nxt),
        .idx  (pick_idx),
        .clr  (clr_nxt)
    );

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        vec_nxt   = vec_q;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    vec_nxt.vdst = bus.in_vdst;
                    vec_nxt.res  = {bus.res_e, bus.res_d, bus.res_c, bus.res_b, bus.res_a};
                    pend_nxt     = bus.in_mask;
                    state_nxt    = (bus.in_mask != '0) ? DRAIN : FIN;
                end
            end
            DRAIN: begin
                pend_nxt = pend & ~clr_q;
                if (pend_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered write port and completion pulse
    always_comb begin
        wr_en_nxt = (state_nxt == DRAIN);
        wr_nxt    = '0;
        if (wr_en_nxt) begin
            wr_nxt.vreg = vec_nxt.vdst;
            wr_nxt.lane = pick_idx;
            wr_nxt.data = vec_nxt.res[pick_idx];
        end
        done_nxt = (state_nxt == FIN) ||
                   (wr_en_nxt && ((pend_nxt & (pend_nxt - LANES'(1))) == '0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pend    <= '0;
            clr_q   <= '0;
            vec_q   <= '0;
            wr_q    <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            clr_q   <= clr_nxt;
            vec_q   <= vec_nxt;
            wr_q    <= wr_nxt;
            wr_en_q <= wr_en_nxt;
            done_q  <= done_nxt;
            ready_q <= (state_nxt == IDLE);
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_vreg  = wr_q.vreg;
    assign bus.wr_lane  = wr_q.lane;
    assign bus.wr_data  = wr_q.data;
    assign bus.done     = done_q;

    // Query must see the current cycle, so this is the one combinational output
    assign bus.stall = bus.chk_en && (state != IDLE) && (bus.chk_vreg == vec_q.vdst);

`ifdef VWB_FLAGS_EN
    logic [LANES-1:0]   mask_q, mask_nxt;
    logic [FLAGS_W-1:0] flags_q, flags_nxt;

    // Flags of the completing vector; later lanes overwrite N so the highest masked lane wins
    always_comb begin
        mask_nxt = mask_q;
        if (state == IDLE && bus.in_valid) begin
            mask_nxt = bus.in_mask;
        end
        flags_nxt = flags_q;
        if (done_nxt) begin
            flags_nxt         = '0;
            flags_nxt[FLAG_Z] = 1'b1;
            flags_nxt[FLAG_C] = 1'b0;
            flags_nxt[FLAG_V] = 1'b0;
            for (int i = 0; i < int'(LANES); i++) begin
                if (mask_nxt[i]) begin
                    if (vec_nxt.res[i] != '0) begin
                        flags_nxt[FLAG_Z] = 1'b0;
                    end
                    flags_nxt[FLAG_N] = vec_nxt.res[i][DATA_W-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q  <= '0;
            flags_q <= '0;
        end else begin
            mask_q  <= mask_nxt;
            flags_q <= flags_nxt;
        end
    end

    assign bus.vflags = flags_q;
`else
    assign bus.vflags = '0;
`endif

endmodule

// File: tb/tb_vec_writeback.sv
// Scoreboard bench for vec_writeback: directed vectors push expected writes, a monitor pops and compares.
module tb_vec_writeback;
    import vec_pkg::*;

    typedef struct {
        logic        en;
        logic [2:0]  vreg;
        logic [2:0]  lane;
        logic [31:0] data;
        logic        done;
        logic [3:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vec_writeback_if bus ();

    vec_writeback dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks      = 0;
    int   failures    = 0;
    int   writes_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write or completion pulse must match the head of the scoreboard
    always @(negedge clk) begin : monitor
        exp_t ex;
        if (reset === 1'b1 && (bus.wr_en === 1'b1 || bus.done === 1'b1)) begin
            if (bus.wr_en === 1'b1) writes_seen++;
            if (sb.size() == 0) begin
                check("unexpected_output", {62'd0, bus.wr_en, bus.done}, 64'd0);
            end else begin
                ex = sb.pop_front();
                check("sb_wr_en", bus.wr_en, ex.en);
                if (ex.en) begin
                    check("sb_wr_vreg", bus.wr_vreg, ex.vreg);
                    check("sb_wr_lane", bus.wr_lane, ex.lane);
                    check("sb_wr_data", bus.wr_data, ex.data);
                end
                check("sb_done", bus.done, ex.done);
                if (ex.done) check("sb_vflags", bus.vflags, ex.flags);
            end
        end
    end

    // Drive one vector at a negedge (after waiting for in_ready) and queue its expected writes
    task automatic drive_vec(input logic [2:0] vdst, input logic [4:0] mask,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] d, input logic [31:0] e, input logic [3:0] fl);
        int          n;
        int          last;
        logic [31:0] r[5];
        logic [3:0]  ef;
        exp_t        x;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) check("ready_timeout", bus.in_ready, 1);
`ifdef VWB_FLAGS_EN
        ef = fl;
`else
        ef = 4'b0000;
`endif
        bus.in_valid = 1'b1;
        bus.in_vdst  = vdst;
        bus.in_mask  = mask;
        bus.res_a = a; bus.res_b = b; bus.res_c = c; bus.res_d = d; bus.res_e = e;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
        last = -1;
        for (int i = 0; i < 5; i++) if (mask[i]) last = i;
        if (mask == 5'd0) begin
            x = '{en: 1'b0, vreg: 3'd0, lane: 3'd0, data: 32'd0, done: 1'b1, flags: ef};
            sb.push_back(x);
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (mask[i]) begin
                    x = '{en: 1'b1, vreg: vdst, lane: 3'(i), data: r[i],
                          done: (i == last), flags: ef};
                    sb.push_back(x);
                end
            end
        end
    endtask

    task automatic send(input logic [2:0] vdst, input logic [4:0] mask,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d, input logic [31:0] e, input logic [3:0] fl);
        drive_vec(vdst, mask, a, b, c, d, e, fl);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w0;
        int n;
        bus.in_valid = 1'b0; bus.in_vdst = '0; bus.in_mask = '0;
        bus.res_a = '0; bus.res_b = '0; bus.res_c = '0; bus.res_d = '0; bus.res_e = '0;
        bus.chk_en = 1'b1; bus.chk_vreg = 3'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_wr_en",    bus.wr_en, 0);
        check("rst_wr_data",  bus.wr_data, 0);
        check("rst_done",     bus.done, 0);
        check("rst_stall",    bus.stall, 0);
        check("rst_vflags",   bus.vflags, 0);
        bus.chk_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Full vector: five consecutive writes, ready in the sixth cycle
        w0 = writes_seen;
        send(3'd3, 5'b11111, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            check("full_wr_en", bus.wr_en, 1);
            check("full_busy",  bus.in_ready, 0);
            @(negedge clk);
        end
        check("full_ready_back", bus.in_ready, 1);
        check("full_idle_wr_en", bus.wr_en, 0);
        check("full_write_count", 64'(writes_seen - w0), 64'd5);

        // Sparse mask: lane 1 then lane 4
        w0 = writes_seen;
        send(3'd1, 5'b10010, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd7, 4'b0000);
        repeat (2) @(negedge clk);
        check("sparse_ready_back", bus.in_ready, 1);
        check("sparse_write_count", 64'(writes_seen - w0), 64'd2);

        // Zero mask: done only, FIN counts as busy, acceptance cycle does not stall
        w0 = writes_seen;
        bus.chk_en = 1'b1; bus.chk_vreg = 3'd6;
        drive_vec(3'd6, 5'b00000, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 4'b0100);
        #1 check("zero_accept_nostall", bus.stall, 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("zero_done",     bus.done, 1);
        check("zero_no_write", bus.wr_en, 0);
        check("zero_fin_stall", bus.stall, 1);
        check("zero_busy",     bus.in_ready, 0);
`ifdef VWB_FLAGS_EN
        check("zero_vflags", bus.vflags, 4'b0100);
`else
        check("zero_vflags", bus.vflags, 4'b0000);
`endif
        @(negedge clk);
        check("zero_done_pulse", bus.done, 0);
        check("zero_ready_back", bus.in_ready, 1);
        check("zero_idle_stall", bus.stall, 0);
        check("zero_write_count", 64'(writes_seen - w0), 64'd0);
        bus.chk_en = 1'b0;

        // Hazard while draining vdst=2
        send(3'd2, 5'b11111, 32'd10, 32'd20, 32'd30, 32'd40, 32'hFFFF_0000, 4'b1000);
        bus.chk_en = 1'b1; bus.chk_vreg = 3'd2;
        #1 check("haz_match", bus.stall, 1);
        bus.chk_vreg = 3'd5;
        #1 check("haz_other", bus.stall, 0);
        bus.chk_vreg = 3'd2;
        repeat (4) @(negedge clk);
        #1 check("haz_last_write", bus.stall, 1);
        check("haz_last_done", bus.done, 1);
        @(negedge clk);
        #1 check("haz_idle", bus.stall, 0);
        bus.chk_en = 1'b0;

        // Flags: highest masked lane has bit31 set, not all zero
        send(3'd4, 5'b00011, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 4'b1000);
        repeat (4) @(negedge clk);
        check("flags_ready", bus.in_ready, 1);
`ifdef VWB_FLAGS_EN
        check("flags_held", bus.vflags, 4'b1000);
`else
        check("flags_tied", bus.vflags, 4'b0000);
`endif

        // in_valid while busy is ignored
        w0 = writes_seen;
        send(3'd7, 5'b00100, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 4'b0000);
        bus.in_valid = 1'b1; bus.in_vdst = 3'd1; bus.in_mask = 5'b11111;
        @(negedge clk);
        check("busy_ignore_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_ignore_count", 64'(writes_seen - w0), 64'd1);

        // Reset after the second write of a full vector
        send(3'd5, 5'b11111, 32'd11, 32'd22, 32'd33, 32'd44, 32'd55, 4'b0000);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_wr_en",    bus.wr_en, 0);
        check("rst_mid_ready",    bus.in_ready, 1);
        check("rst_mid_done",     bus.done, 0);
        check("rst_mid_wr_data",  bus.wr_data, 0);
        check("rst_mid_vflags",   bus.vflags, 0);
        sb.delete();
        w0 = writes_seen;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_no_writes", 64'(writes_seen - w0), 64'd0);
        check("rst_mid_ready_after", bus.in_ready, 1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
